id_branch_seg: RTL and testbench

//  Decode-side partner of the fetch segment: latches fetched {NPC, IR} into the IF/ID register,

---
 rtl/id_branch_seg_pkg.sv | 50 +++++
 rtl/id_branch_seg_if.sv | 34 +++
 rtl/id_branch_seg_btu.sv | 48 ++++
 rtl/id_branch_seg.sv | 103 ++++++++++
 tb/tb_id_branch_seg.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_branch_seg_pkg.sv
// Shared decode constants and helpers for the ID-stage branch resolver.
// Also defines the IF/ID update action and the control-transfer class.
package id_branch_seg_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        UpdLoad,
        UpdHold,
        UpdBubble
    } ifid_upd_e;

    typedef enum logic [2:0] {
        CtNone,
        CtBeq,
        CtBne,
        CtJump,
        CtJr
    } ctrl_kind_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] ir);
        return ir[5:0];
    endfunction

    function automatic ctrl_kind_e classify(input logic [31:0] ir);
        ctrl_kind_e kind;
        kind = CtNone;
        case (opcode_of(ir))
            OP_BEQ:        kind = CtBeq;
            OP_BNE:        kind = CtBne;
            OP_J, OP_JAL:  kind = CtJump;
            OP_RTYPE:      kind = (funct_of(ir) == FN_JR) ? CtJr : CtNone;
            default:       kind = CtNone;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/id_branch_seg_if.sv
// Fetch/regfile-facing signal bundle of the ID branch segment.
// The slave modport is the segment itself; master is its environment.
interface id_branch_seg_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      npc_in;
    logic [31:0]      ir_in;
    logic             stall;
    logic             flush;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [31:0]      id_npc;
    logic [31:0]      id_ir;
    logic             id_valid;
    logic             cond;
    logic [31:0]      cond_npc;
    logic             link_we;
    logic [31:0]      link_val;
    logic [CNT_W-1:0] taken_cnt;

    modport slave (
        input  npc_in, ir_in, stall, flush, rs_data, rt_data,
        output rs_addr, rt_addr, id_npc, id_ir, id_valid, cond, cond_npc,
               link_we, link_val, taken_cnt
    );

    modport master (
        output npc_in, ir_in, stall, flush, rs_data, rt_data,
        input  rs_addr, rt_addr, id_npc, id_ir, id_valid, cond, cond_npc,
               link_we, link_val, taken_cnt
    );
endinterface

// File: rtl/id_branch_seg_btu.sv
// Branch target unit: purely combinational resolution of the instruction in ID.
// Produces the unqualified taken flag, the redirect target and a jal marker.
module id_branch_seg_btu
    import id_branch_seg_pkg::*;
(
    input  logic [31:0] id_ir_i,
    input  logic [31:0] id_npc_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic        taken_raw_o,
    output logic [31:0] target_o,
    output logic        is_jal_o
);

    ctrl_kind_e  kind;
    logic [31:0] br_off;

    always_comb begin
        kind        = classify(id_ir_i);
        br_off      = {{14{id_ir_i[15]}}, id_ir_i[15:0], 2'b00};
        taken_raw_o = 1'b0;
        target_o    = '0;
        is_jal_o    = (opcode_of(id_ir_i) == OP_JAL);
        unique case (kind)
            CtBeq: begin
                taken_raw_o = (rs_data_i == rt_data_i);
                target_o    = id_npc_i + br_off;
            end
            CtBne: begin
                taken_raw_o = (rs_data_i != rt_data_i);
                target_o    = id_npc_i + br_off;
            end
            CtJump: begin
                taken_raw_o = 1'b1;
                target_o    = {id_npc_i[31:28], id_ir_i[25:0], 2'b00};
            end
            CtJr: begin
                taken_raw_o = 1'b1;
                target_o    = rs_data_i;
            end
            default: begin
                taken_raw_o = 1'b0;
                target_o    = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_branch_seg.sv
// ID-side IF/ID register with zero-latency branch/jump redirect back to fetch.
// cond=0 tells fetch to take cond_npc; each redirect inserts exactly one bubble.
module id_branch_seg
    import id_branch_seg_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input logic           clk,
    input logic           rst,
    id_branch_seg_if.slave bus
);

    logic [31:0]      id_ir_q, id_ir_d;
    logic [31:0]      id_npc_q, id_npc_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic        taken_raw;
    logic [31:0] target;
    logic        is_jal;
    logic        live;
    logic        taken;
    ifid_upd_e   upd;

    id_branch_seg_btu u_btu (
        .id_ir_i     (id_ir_q),
        .id_npc_i    (id_npc_q),
        .rs_data_i   (bus.rs_data),
        .rt_data_i   (bus.rt_data),
        .taken_raw_o (taken_raw),
        .target_o    (target),
        .is_jal_o    (is_jal)
    );

    always_comb begin
        // A held or squashed instruction must not redirect or link.
        live  = id_valid_q & ~bus.stall & ~bus.flush;
        taken = live & taken_raw;

        if (bus.flush) begin
            upd = UpdBubble;
        end else if (bus.stall) begin
            upd = UpdHold;
        end else if (taken) begin
            upd = UpdBubble;
        end else begin
            upd = UpdLoad;
        end

        id_ir_d    = id_ir_q;
        id_npc_d   = id_npc_q;
        id_valid_d = id_valid_q;
        unique case (upd)
            UpdLoad: begin
                id_ir_d    = bus.ir_in;
                id_npc_d   = bus.npc_in;
                id_valid_d = 1'b1;
            end
            UpdBubble: begin
                id_ir_d    = NOP_INST;
                id_npc_d   = '0;
                id_valid_d = 1'b0;
            end
            default: begin
                id_ir_d    = id_ir_q;
                id_npc_d   = id_npc_q;
                id_valid_d = id_valid_q;
            end
        endcase

        taken_cnt_d = taken_cnt_q;
        if (taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ir_q     <= NOP_INST;
            id_npc_q    <= '0;
            id_valid_q  <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            id_ir_q     <= id_ir_d;
            id_npc_q    <= id_npc_d;
            id_valid_q  <= id_valid_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.rs_addr   = id_ir_q[25:21];
    assign bus.rt_addr   = id_ir_q[20:16];
    assign bus.id_ir     = id_ir_q;
    assign bus.id_npc    = id_npc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.cond      = ~taken;
    assign bus.cond_npc  = taken ? target : 32'h0;
    assign bus.link_we   = live & is_jal;
    assign bus.link_val  = id_npc_q;
    assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_id_branch_seg.sv
// Bench for id_branch_seg: directed literal checks plus randomized traffic against
// a behavioural model; two DUTs (16-bit and 2-bit counters) share the stimulus.
module tb_id_branch_seg;

    logic        clk;
    logic        rst;
    logic [31:0] npc_in, ir_in, rs_data, rt_data;
    logic        stall, flush;

    int checks = 0;
    int errors = 0;

    id_branch_seg_if #(.CNT_W(16)) bus_a ();
    id_branch_seg_if #(.CNT_W(2))  bus_b ();

    assign bus_a.npc_in  = npc_in;
    assign bus_a.ir_in   = ir_in;
    assign bus_a.stall   = stall;
    assign bus_a.flush   = flush;
    assign bus_a.rs_data = rs_data;
    assign bus_a.rt_data = rt_data;
    assign bus_b.npc_in  = npc_in;
    assign bus_b.ir_in   = ir_in;
    assign bus_b.stall   = stall;
    assign bus_b.flush   = flush;
    assign bus_b.rs_data = rs_data;
    assign bus_b.rt_data = rt_data;

    id_branch_seg #(.CNT_W(16), .NOP_INST(32'h0000_0000)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    id_branch_seg #(.CNT_W(2), .NOP_INST(32'h0000_0000)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the instruction sitting in ID.
    logic [31:0] m_ir, m_npc;
    logic        m_valid;
    int unsigned m_cnt;
    bit          m_known = 1'b0;

    function automatic bit ref_live();
        return m_valid && !stall && !flush;
    endfunction

    function automatic bit ref_taken();
        bit t;
        t = 1'b0;
        case (m_ir[31:26])
            6'h04:        t = (rs_data == rt_data);
            6'h05:        t = (rs_data != rt_data);
            6'h02, 6'h03: t = 1'b1;
            6'h00:        t = (m_ir[5:0] == 6'h08);
            default:      t = 1'b0;
        endcase
        return t && ref_live();
    endfunction

    function automatic logic [31:0] ref_target();
        int          off;
        logic [31:0] tgt;
        off = int'($signed(m_ir[15:0])) * 4;
        case (m_ir[31:26])
            6'h04, 6'h05: tgt = m_npc + 32'(off);
            6'h02, 6'h03: tgt = (m_npc & 32'hF000_0000) | (32'(m_ir[25:0]) << 2);
            default:      tgt = rs_data;
        endcase
        return ref_taken() ? tgt : 32'h0;
    endfunction

    function automatic bit ref_link();
        return ref_live() && (m_ir[31:26] == 6'h03);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ir    <= 32'h0;
            m_npc   <= 32'h0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_known <= 1'b1;
        end else if (m_known) begin
            if (flush || (!stall && ref_taken())) begin
                m_ir    <= 32'h0;
                m_npc   <= 32'h0;
                m_valid <= 1'b0;
            end else if (!stall) begin
                m_ir    <= ir_in;
                m_npc   <= npc_in;
                m_valid <= 1'b1;
            end
            if (ref_taken()) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("cond",     64'(bus_a.cond),      64'(!ref_taken()));
            chk("cond_npc", 64'(bus_a.cond_npc),  64'(ref_target()));
            chk("id_ir",    64'(bus_a.id_ir),     64'(m_ir));
            chk("id_npc",   64'(bus_a.id_npc),    64'(m_npc));
            chk("id_valid", 64'(bus_a.id_valid),  64'(m_valid));
            chk("rs_addr",  64'(bus_a.rs_addr),   64'(m_ir[25:21]));
            chk("rt_addr",  64'(bus_a.rt_addr),   64'(m_ir[20:16]));
            chk("link_we",  64'(bus_a.link_we),   64'(ref_link()));
            chk("link_val", 64'(bus_a.link_val),  64'(m_npc));
            chk("cnt16",    64'(bus_a.taken_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
            chk("cnt2",     64'(bus_b.taken_cnt), 64'((m_cnt > 3) ? 3 : m_cnt));
            chk("cond_b",   64'(bus_b.cond),      64'(!ref_taken()));
        end
    end

    task automatic drive(input bit r, input logic [31:0] ir, input logic [31:0] npc,
                         input bit st, input bit fl, input logic [31:0] rs,
                         input logic [31:0] rt);
        @(posedge clk);
        #1;
        rst     = r;
        ir_in   = ir;
        npc_in  = npc;
        stall   = st;
        flush   = fl;
        rs_data = rs;
        rt_data = rt;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0:       r[31:26] = 6'h04;
            1:       r[31:26] = 6'h05;
            2:       r[31:26] = 6'h02;
            3:       r[31:26] = 6'h03;
            4: begin
                r[31:26] = 6'h00;
                r[5:0]   = 6'h08;
            end
            5:       r[31:26] = 6'h08;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] rv;
        rst = 1'b1; ir_in = 0; npc_in = 0; stall = 0; flush = 0; rs_data = 0; rt_data = 0;

        // 1: reset then a plain instruction enters ID
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_valid", 64'(bus_a.id_valid), 64'd0);
        chk("rst_cond",  64'(bus_a.cond), 64'd1);
        drive(0, 32'h2008_0005, 32'd4, 0, 0, 0, 0);
        drive(0, 32'h1022_0003, 32'd8, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_ir",    64'(bus_a.id_ir), 64'h2008_0005);
        chk("t1_npc",   64'(bus_a.id_npc), 64'd4);
        chk("t1_valid", 64'(bus_a.id_valid), 64'd1);
        chk("t1_cnt",   64'(bus_a.taken_cnt), 64'd0);

        // 2: beq taken then not taken
        drive(0, 32'h0, 32'd12, 0, 0, 32'd7, 32'd7);
        @(negedge clk);
        chk("t2_cond",  64'(bus_a.cond), 64'd0);
        chk("t2_npc",   64'(bus_a.cond_npc), 64'h14);
        drive(0, 32'h0, 32'd16, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_bub",   64'(bus_a.id_valid), 64'd0);
        chk("t2_cnt",   64'(bus_a.taken_cnt), 64'd1);
        drive(0, 32'h1022_0003, 32'd8, 0, 0, 0, 0);
        drive(0, 32'h0, 32'd12, 0, 0, 32'd7, 32'd8);
        @(negedge clk);
        chk("t2_nt",    64'(bus_a.cond), 64'd1);
        drive(0, 32'h0, 32'd16, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_nobub", 64'(bus_a.id_valid), 64'd1);

        // 3: j and jal
        drive(0, 32'h0800_0040, 32'hF000_0010, 0, 0, 0, 0);
        drive(0, 32'h0, 32'hF000_0014, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_j", 64'(bus_a.cond_npc), 64'hF000_0100);
        drive(0, 32'h0C00_0040, 32'hF000_0010, 0, 0, 0, 0);
        drive(0, 32'h0, 32'hF000_0014, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_lwe",  64'(bus_a.link_we), 64'd1);
        chk("t3_lval", 64'(bus_a.link_val), 64'hF000_0010);
        chk("t3_jal",  64'(bus_a.cond_npc), 64'hF000_0100);

        // 4: bne wrapping backwards, jr
        drive(0, 32'h1422_FFFF, 32'd0, 0, 0, 0, 0);
        drive(0, 32'h0, 32'd4, 0, 0, 32'd1, 32'd2);
        @(negedge clk);
        chk("t4_bne", 64'(bus_a.cond_npc), 64'hFFFF_FFFC);
        drive(0, 32'h0020_0008, 32'h100, 0, 0, 0, 0);
        drive(0, 32'h0, 32'h104, 0, 0, 32'h40, 0);
        @(negedge clk);
        chk("t4_jr", 64'(bus_a.cond_npc), 64'h40);

        // 5: stalled taken beq, then flush+stall
        drive(0, 32'h1022_0003, 32'd8, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 32'd12, 1, 0, 32'd7, 32'd7);
            @(negedge clk);
            chk("t5_hold_cond", 64'(bus_a.cond), 64'd1);
            chk("t5_hold_ir",   64'(bus_a.id_ir), 64'h1022_0003);
        end
        drive(0, 32'h0, 32'd12, 0, 0, 32'd7, 32'd7);
        @(negedge clk);
        chk("t5_go", 64'(bus_a.cond), 64'd0);
        drive(0, 32'h0, 32'd16, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_bub", 64'(bus_a.id_valid), 64'd0);
        chk("t5_cnt", 64'(bus_a.taken_cnt), 64'd6);
        drive(0, 32'h1022_0003, 32'd8, 0, 0, 0, 0);
        drive(0, 32'h0, 32'd12, 1, 1, 32'd7, 32'd7);
        @(negedge clk);
        chk("t5_fs_cond", 64'(bus_a.cond), 64'd1);
        drive(0, 32'h0, 32'd16, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_fs_valid", 64'(bus_a.id_valid), 64'd0);
        chk("t5_fs_ir",    64'(bus_a.id_ir), 64'd0);

        // 6: counter saturation in the 2-bit instance, then mid-stream reset
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0800_0040, 32'd4, 0, 0, 0, 0);
            drive(0, 32'h0, 32'd8, 0, 0, 0, 0);
        end
        drive(0, 32'h0, 32'd8, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_sat2",  64'(bus_b.taken_cnt), 64'd3);
        chk("t6_cnt16", 64'(bus_a.taken_cnt), 64'd4);
        drive(0, 32'h0800_0040, 32'd4, 0, 0, 0, 0);
        drive(1, 32'h0, 32'd8, 0, 0, 0, 0);
        drive(0, 32'h0, 32'd12, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_rst_valid", 64'(bus_a.id_valid), 64'd0);
        chk("t6_rst_cnt",   64'(bus_b.taken_cnt), 64'd0);
        chk("t6_rst_cond",  64'(bus_a.cond), 64'd1);

        // Randomized traffic, checked every cycle by the model comparator
        for (int i = 0; i < 3000; i++) begin
            rv = $urandom;
            drive(($urandom_range(0, 99) == 0),
                  rand_inst(),
                  $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 5),
                  rv,
                  ($urandom_range(0, 1) == 1) ? rv : $urandom);
        end
        @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
